// File: rtl/fetch_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned PC_INC        = 4;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold,
    StFlush
  } fetch_state_e;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic                valid;
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] pc4;
    logic [31:0]         instr;
  } ifid_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry buffer that parks a fetched instruction while the pipeline is stalled.
// discard has priority over load, load over release.
module fetch_hold_buf #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            release_en,
  input  logic            discard,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            occupied,
  output logic [XLEN-1:0] held_pc,
  output logic [31:0]     held_instr
);

  logic            occupied_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;

  // Capture on load, free the entry on release or discard
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occupied_q <= 1'b0;
      pc_q       <= '0;
      instr_q    <= '0;
    end else if (discard) begin
      occupied_q <= 1'b0;
    end else if (load) begin
      occupied_q <= 1'b1;
      pc_q       <= load_pc;
      instr_q    <= load_instr;
    end else if (release_en) begin
      occupied_q <= 1'b0;
    end
  end

  assign occupied   = occupied_q;
  assign held_pc    = pc_q;
  assign held_instr = instr_q;

endmodule

// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch stage: req/ready fetch from instruction memory,
// IF/ID register load, stall hold and branch redirect/flush.
// Optional macro PERF_CNT_EN adds fetch_count / flush_count performance outputs.
module pc_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4,
  output logic [31:0]     if_instr
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]     fetch_count,
  output logic [15:0]     flush_count
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  ifid_t           ifid_q, ifid_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] held_pc;
  logic [31:0]     held_instr;
  logic            hb_occupied;

  logic redirect;
  logic fetch_load;
  logic hold_capture;
  logic hold_release;

  // pc + 4 wraps modulo 2^XLEN by construction
  assign pc_plus4 = pc_q + XLEN'(PC_INC);

  // A taken branch overrides stall and ready everywhere except IDLE
  assign redirect     = branch_taken && (state_q != StIdle);
  assign fetch_load   = (state_q == StReq) && !redirect && imem_ready && !stall;
  assign hold_capture = (state_q == StReq) && !redirect && imem_ready && stall;
  assign hold_release = (state_q == StHold) && !redirect && !stall && hb_occupied;

  fetch_hold_buf #(
    .XLEN (XLEN)
  ) u_hold_buf (
    .clock      (clock),
    .reset      (reset),
    .load       (hold_capture),
    .release_en (hold_release),
    .discard    (redirect),
    .load_pc    (pc_q),
    .load_instr (imem_rdata),
    .occupied   (hb_occupied),
    .held_pc    (held_pc),
    .held_instr (held_instr)
  );

  // Next-state, next-PC and IF/ID update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    if (redirect) begin
      pc_d         = branch_target & ~XLEN'(3);
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP_INSTR;
      state_d      = StFlush;
    end else begin
      unique case (state_q)
        StIdle: state_d = StReq;
        StReq: begin
          if (fetch_load) begin
            ifid_d = '{valid: 1'b1, pc: XLEN_DEF'(pc_q), pc4: XLEN_DEF'(pc_plus4),
                       instr: imem_rdata};
            pc_d   = pc_plus4;
          end else if (hold_capture) begin
            state_d = StHold;
          end else if (!imem_ready && !stall) begin
            ifid_d.valid = 1'b0;
          end
        end
        StHold: begin
          if (hold_release) begin
            ifid_d  = '{valid: 1'b1, pc: XLEN_DEF'(held_pc),
                        pc4: XLEN_DEF'(held_pc + XLEN'(PC_INC)), instr: held_instr};
            pc_d    = pc_plus4;
            state_d = StReq;
          end
        end
        StFlush: state_d = StReq;
        default: state_d = StIdle;
      endcase
    end
  end

  // State, PC and IF/ID registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ifid_q  <= '{valid: 1'b0, pc: '0, pc4: '0, instr: NOP_INSTR};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  // Request is a pure state decode so reset drops it asynchronously
  assign imem_req  = (state_q == StReq);
  assign imem_addr = pc_q;
  assign if_valid  = ifid_q.valid;
  assign if_pc     = XLEN'(ifid_q.pc);
  assign if_pc4    = XLEN'(ifid_q.pc4);
  assign if_instr  = ifid_q.instr;

`ifdef PERF_CNT_EN
  logic [31:0] fetch_count_q;
  logic [15:0] flush_count_q;

  // Fetch counter wraps; flush counter saturates
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (fetch_load || hold_release) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (redirect && (flush_count_q != 16'hFFFF)) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule
